audio_recorder: RTL and testbench

AUDIO_RECORDER -- requirements
Module: audio_recorder

---
 rtl/audio_recorder_if.sv | 13 +
 rtl/audio_recorder.sv | 144 ++++++++++++++
 tb/tb_audio_recorder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_recorder_if.sv
// Sample RAM bus: the recorder drives address/write side (master), a
// synchronous RAM answers with read data one cycle after the address (slave).
interface audio_recorder_if #(
   parameter int ADDR_W = 15
);
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_wdata;
   logic              ram_we;
   logic [15:0]       ram_rdata;

   modport master (output ram_addr, output ram_wdata, output ram_we, input ram_rdata);
   modport slave  (input ram_addr, input ram_wdata, input ram_we, output ram_rdata);
endinterface

// File: rtl/audio_recorder.sv
// Triggered audio recorder: arms on a record request, starts storing ADC
// frames once a sample's magnitude crosses TRIG_LEVEL, and plays the stored
// take back (optionally looping) through the DAC word.
module audio_recorder #(
   parameter int          ADDR_W     = 15,
   parameter logic [15:0] TRIG_LEVEL = 16'd1024
) (
   input  logic             DAC_LR_CLK,
   input  logic             reset,
   input  logic             rec_sw,
   input  logic             play_sw,
   input  logic             loop,
   input  logic [15:0]      adc_sample,
   audio_recorder_if.master ram,
   output logic [15:0]      dac_sample,
   output logic [1:0]       state,
   output logic [ADDR_W:0]  rec_len,
   output logic             full
);
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ARMED  = 2'b01,
      RECORD = 2'b10,
      PLAY   = 2'b11
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
   localparam logic [ADDR_W:0]   LEN_ONE   = 1;

   state_t            state_q;
   logic              rec_dly_q, play_dly_q;
   logic [ADDR_W-1:0] wptr_q, addr_q;
   logic [15:0]       wdata_q, dac_q;
   logic              we_q, full_q;
   logic [ADDR_W:0]   len_q;
   // vld_q[0]: a playback address went out on the last edge;
   // vld_q[1]: the RAM data for that address is on ram_rdata now.
   logic [1:0]        vld_q;

   logic              rec_rise, play_rise, at_last, trig;
   logic [15:0]       mag;

   assign rec_rise  = rec_sw  & ~rec_dly_q;
   assign play_rise = play_sw & ~play_dly_q;
   assign at_last   = ({1'b0, addr_q} == (len_q - LEN_ONE));
   assign trig      = (mag >= TRIG_LEVEL);

   // Sample magnitude; 16'h8000 has no positive twin so it clamps to full scale
   always_comb begin
      mag = adc_sample;
      if (adc_sample == 16'h8000)
         mag = 16'h7FFF;
      else if (adc_sample[15])
         mag = -adc_sample;
   end

   // Control FSM with edge detectors, RAM bus and DAC pipeline, all registered
   always_ff @(posedge DAC_LR_CLK) begin
      if (!reset) begin
         state_q    <= IDLE;
         rec_dly_q  <= 1'b1;
         play_dly_q <= 1'b1;
         wptr_q     <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         len_q      <= '0;
         full_q     <= 1'b0;
         vld_q      <= '0;
         dac_q      <= '0;
      end else begin
         rec_dly_q  <= rec_sw;
         play_dly_q <= play_sw;
         we_q       <= 1'b0;
         vld_q      <= {vld_q[0], 1'b0};
         dac_q      <= vld_q[1] ? ram.ram_rdata : 16'h0000;
         case (state_q)
            IDLE: begin
               if (rec_rise)
                  state_q <= ARMED;
               else if (play_rise && len_q != '0) begin
                  state_q  <= PLAY;
                  addr_q   <= '0;
                  vld_q[0] <= 1'b1;
               end
            end
            ARMED: begin
               if (!rec_sw)
                  state_q <= IDLE;
               else if (trig) begin
                  // the triggering frame itself is the first stored sample
                  state_q <= RECORD;
                  we_q    <= 1'b1;
                  addr_q  <= '0;
                  wdata_q <= adc_sample;
                  wptr_q  <= ADDR_ONE;
                  len_q   <= LEN_ONE;
                  full_q  <= 1'b0;
               end
            end
            RECORD: begin
               if (!rec_sw)
                  state_q <= IDLE;
               else begin
                  we_q    <= 1'b1;
                  addr_q  <= wptr_q;
                  wdata_q <= adc_sample;
                  wptr_q  <= wptr_q + ADDR_ONE;
                  len_q   <= len_q + LEN_ONE;
                  // last slot written: stop rather than overwrite the take
                  if (wptr_q == LAST_ADDR) begin
                     full_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            PLAY: begin
               if (!play_sw)
                  state_q <= IDLE;
               else if (at_last) begin
                  if (loop) begin
                     addr_q   <= '0;
                     vld_q[0] <= 1'b1;
                  end else
                     state_q <= IDLE;
               end else begin
                  addr_q   <= addr_q + ADDR_ONE;
                  vld_q[0] <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram.ram_addr  = addr_q;
   assign ram.ram_wdata = wdata_q;
   assign ram.ram_we    = we_q;
   assign dac_sample    = dac_q;
   assign state         = state_q;
   assign rec_len       = len_q;
   assign full          = full_q;
endmodule

// File: tb/tb_audio_recorder.sv
// Bench for audio_recorder (ADDR_W=3): directed scenarios plus random switch
// and sample traffic, checked every cycle against a behavioural model.
module tb_audio_recorder;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst_n, rec_sw, play_sw, loop_i;
   logic [15:0] adc;
   logic [15:0] dac;
   logic [1:0]  st;
   logic [AW:0] rlen;
   logic        full_o;

   audio_recorder_if #(.ADDR_W(AW)) bus ();

   audio_recorder #(.ADDR_W(AW), .TRIG_LEVEL(16'd1024)) dut (
      .DAC_LR_CLK (clk),
      .reset      (rst_n),
      .rec_sw     (rec_sw),
      .play_sw    (play_sw),
      .loop       (loop_i),
      .adc_sample (adc),
      .ram        (bus),
      .dac_sample (dac),
      .state      (st),
      .rec_len    (rlen),
      .full       (full_o)
   );

   always #5 clk = ~clk;

   // synchronous RAM: read data follows the address by one cycle
   logic [15:0] ram_mem [DEPTH];
   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= ram_mem[bus.ram_addr];
   end

   int n_vec = 0, n_err = 0;
   int n_wr = 0, n_wr0 = 0;
   int q_addr[$];
   int q_dac[$];
   bit chk_en = 1'b0;

   // behavioural model: mode, stored take, and the expected registered outputs
   int          m_st, m_len, m_full;
   bit          m_prev_rec, m_prev_play;
   logic [15:0] m_mem [DEPTH];
   int          m_iss1, m_iss2;
   int          e_addr, e_wdata, e_we, e_dac;

   task automatic chk(input string nm, input int act, input int want);
      if (act != want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, want, $time);
      end
   endtask

   task automatic store();
      m_mem[m_len] = adc;
      e_we    = 1;
      e_addr  = m_len;
      e_wdata = int'(adc);
      m_len++;
      if (m_len == DEPTH) begin
         m_full = 1;
         m_st   = 0;
      end
   endtask

   // advance the model by one rising edge using the inputs now applied
   task automatic step();
      bit rr, pr;
      int mag, iss, nxt;
      iss = -1;
      if (!rst_n) begin
         m_st = 0; m_len = 0; m_full = 0;
         m_prev_rec = 1; m_prev_play = 1;
         e_we = 0; e_addr = 0; e_wdata = 0; e_dac = 0;
         m_iss1 = -1; m_iss2 = -1;
         return;
      end
      e_dac = (m_iss2 >= 0) ? int'(m_mem[m_iss2]) : 0;
      e_we  = 0;
      rr = rec_sw && !m_prev_rec;
      pr = play_sw && !m_prev_play;
      m_prev_rec  = rec_sw;
      m_prev_play = play_sw;
      mag = int'($signed(adc));
      if (mag < 0) mag = -mag;
      if (mag > 32767) mag = 32767;
      case (m_st)
         0: if (rr) m_st = 1;
            else if (pr && m_len > 0) begin m_st = 3; e_addr = 0; iss = 0; end
         1: if (!rec_sw) m_st = 0;
            else if (mag >= 1024) begin m_len = 0; m_full = 0; m_st = 2; store(); end
         2: if (!rec_sw) m_st = 0; else store();
         default: if (!play_sw) m_st = 0;
            else begin
               nxt = e_addr + 1;
               if (nxt < m_len) begin e_addr = nxt; iss = nxt; end
               else if (loop_i) begin e_addr = 0; iss = 0; end
               else m_st = 0;
            end
      endcase
      m_iss2 = m_iss1;
      m_iss1 = iss;
   endtask

   task automatic cyc(input logic r, input logic p, input logic l,
                      input logic [15:0] a, input logic rs = 1'b1);
      @(posedge clk);
      #2;
      rec_sw = r; play_sw = p; loop_i = l; adc = a; rst_n = rs;
      step();
      chk_en = 1'b1;
      n_vec++;
   endtask

   // per-cycle compare of every output against the model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("state", int'(st), m_st);
         chk("ram_we", int'(bus.ram_we), e_we);
         chk("ram_addr", int'(bus.ram_addr), e_addr);
         chk("ram_wdata", int'(bus.ram_wdata), e_wdata);
         chk("dac_sample", int'(dac), e_dac);
         chk("rec_len", int'(rlen), m_len);
         chk("full", int'(full_o), m_full);
         if (bus.ram_we) begin
            n_wr++;
            if (bus.ram_addr == '0) n_wr0++;
         end
         if (st == 2'b11) q_addr.push_back(int'(bus.ram_addr));
         if (dac != 16'h0) q_dac.push_back(int'(dac));
      end
   end

   task automatic take3();
      cyc(1, 0, 0, 16'd100);
      cyc(1, 0, 0, 16'd100);
      cyc(1, 0, 0, 16'hFC00);
      cyc(1, 0, 0, 16'd5);
      cyc(1, 0, 0, 16'd6);
      cyc(0, 0, 0, 16'd7);
      repeat (2) cyc(0, 0, 0, 16'd0);
   endtask

   initial begin
      rst_n = 1'b0; rec_sw = 1'b1; play_sw = 1'b1; loop_i = 1'b0; adc = '0;

      // switches held high through reset must not trigger afterwards
      cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      repeat (3) cyc(1, 1, 0, 0);
      chk("hold_idle", int'(st), 0);
      chk("reset_len", int'(rlen), 0);

      // play with nothing recorded is ignored
      cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
      chk("play_empty", int'(st), 0);

      // trigger on -1024, store three samples
      take3();
      chk("len3", int'(rlen), 3);
      chk("full3", int'(full_o), 0);
      chk("mem0", int'(ram_mem[0]), 16'hFC00);
      chk("mem1", int'(ram_mem[1]), 16'h0005);
      chk("mem2", int'(ram_mem[2]), 16'h0006);

      // one-shot playback
      q_addr.delete(); q_dac.delete();
      repeat (7) cyc(0, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      chk("play_addr_n", q_addr.size(), 3);
      chk("play_dac_n", q_dac.size(), 3);
      for (int i = 0; i < 3; i++) if (i < q_addr.size()) chk("play_addr", q_addr[i], i);
      if (q_dac.size() > 2) begin
         chk("play_dac0", q_dac[0], 16'hFC00);
         chk("play_dac1", q_dac[1], 16'h0005);
         chk("play_dac2", q_dac[2], 16'h0006);
      end
      chk("play_end", int'(st), 0);

      // fill the RAM: 8 writes, then idle with rec still high
      n_wr = 0; n_wr0 = 0;
      cyc(1, 0, 0, 16'd0);
      cyc(1, 0, 0, 16'h0400);
      for (int i = 1; i <= 10; i++) cyc(1, 0, 0, 16'(i));
      chk("full_state", int'(st), 0);
      chk("full_flag", int'(full_o), 1);
      chk("full_len", int'(rlen), 8);
      chk("full_wr", n_wr, 8);
      chk("full_wr0", n_wr0, 1);
      repeat (2) cyc(0, 0, 0, 0);
      chk("full_mem7", int'(ram_mem[7]), 7);

      // looped playback over three samples, then abort
      take3();
      q_addr.delete();
      repeat (10) cyc(0, 1, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      chk("loop_n", q_addr.size(), 10);
      for (int i = 0; i < 9; i++) if (i < q_addr.size()) chk("loop_addr", q_addr[i], i % 3);
      chk("loop_abort", int'(st), 0);

      // simultaneous rises arm; 16'h8000 triggers
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 16'h8000);
      chk("both_armed", int'(st), 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("neg_full_mem", int'(ram_mem[0]), 16'h8000);
      chk("neg_full_len", int'(rlen), 1);

      // reset while recording at address 4
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 16'd2000);
      for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 16'(i));
      cyc(1, 0, 0, 16'd9, 0);
      cyc(0, 0, 0, 0);
      chk("rst_state", int'(st), 0);
      chk("rst_we", int'(bus.ram_we), 0);
      chk("rst_len", int'(rlen), 0);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
      chk("rst_noplay", int'(st), 0);

      // random traffic
      begin
         logic r, p, l;
         logic [15:0] a;
         r = 0; p = 0; l = 0;
         for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) r = ~r;
            if ($urandom_range(7) == 0) p = ~p;
            if ($urandom_range(15) == 0) l = ~l;
            case ($urandom_range(3))
               0: a = 16'($urandom);
               1: a = 16'($urandom_range(1100));
               2: a = 16'h8000;
               default: a = 16'(-$urandom_range(1100));
            endcase
            cyc(r, p, l, a, ($urandom_range(149) != 0));
         end
      end
      cyc(0, 0, 0, 0);
      @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
